// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Holds the ALU control codes used by the ALU controller, the ALU and the
// multiply sequencer, plus the multiply sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_MULT = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  function automatic logic is_mult(input logic [3:0] ctrl, input logic [3:0] mult_code);
    return ctrl == mult_code;
  endfunction

endpackage

// File: rtl/mult_iter_dp.sv
// Shift-and-add multiply datapath.
// Holds the accumulator, the left-shifting multiplicand and the
// right-shifting multiplier. One iteration per asserted step.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clear       zero all registers (abort)
//   load        capture src1/src2, zero the accumulator
//   step        perform one shift-and-add iteration
//   src1, src2  multiplicand / multiplier operands
//   acc         current accumulator value
//   acc_step    accumulator value after the current iteration, so the
//               caller can capture the final product on the last step
module mult_iter_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] acc_step
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // Carry out of the add is dropped: product is modulo 2^WIDTH.
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (clear) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= src1;
      mplier <= src2;
    end else if (step) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle multiply sequencer for the EX stage.
// Holds the front of the pipeline while a shift-and-add multiply runs for
// WIDTH cycles, then drops the stall for one cycle with done_o and the
// product on result_o.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i        EX holds a real instruction
//   alu_ctrl_i     ALU control code of the EX instruction
//   src1_i/src2_i  multiplicand / multiplier
//   flush_i        EX instruction squashed; aborts the multiply
//   stall_o        freeze PC, IF/ID, ID/EX; bubble into EX/MEM
//   busy_o         iterating
//   done_o         one-cycle pulse, result_o valid
//   result_o       low WIDTH bits of the product, held until next completion
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a mult in EX; stall raised combinationally on start
// ST_RUN  | one shift-and-add iteration per cycle, WIDTH iterations
// ST_DONE | product in result_o, done_o pulsed, pipeline released
module mult_sequencer
  import alu_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter logic [3:0] CTRL_MULT = 4'd3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mult_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             start;
  logic             last_iter;
  logic             dp_load, dp_step, dp_clear, res_load;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;

  // Reset gates start so stall_o reads 0 while rst_i is held.
  assign start = valid_i && is_mult(alu_ctrl_i, CTRL_MULT) && (state == ST_IDLE)
                 && !flush_i && !rst_i;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    dp_clear  = 1'b0;
    res_load  = 1'b0;
    if (flush_i) begin
      state_nxt = ST_IDLE;
      dp_clear  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_RUN;
            dp_load   = 1'b1;
          end
        end
        ST_RUN: begin
          dp_step = 1'b1;
          if (last_iter) begin
            state_nxt = ST_DONE;
            // Capture the post-iteration accumulator so result_o is already
            // valid during the DONE cycle.
            res_load  = 1'b1;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   cnt <= '0;
    else if (dp_clear || dp_load) cnt <= '0;
    else if (dp_step)             cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         result_o <= '0;
    else if (res_load) result_o <= acc_step;
  end

  mult_iter_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (dp_clear),
    .load     (dp_load),
    .step     (dp_step),
    .src1     (src1_i),
    .src2     (src2_i),
    .acc      (acc),
    .acc_step (acc_step)
  );

  assign stall_o = !flush_i && (start || (state == ST_RUN));
  assign busy_o  = (state == ST_RUN);
  assign done_o  = (state == ST_DONE) && !flush_i;

endmodule
